// File: rtl/serial_adder_sequencer.sv
// Bit-serial N-bit adder: one full-adder cell (two half adders plus an OR) is
// reused for every operand bit, one bit per clock, behind valid/ready handshakes.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_sequencer #(
  parameter int unsigned N = 8
) (
  input  logic         CLKIN,
  input  logic         RESET,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] SUM,
  output logic         COUT,
  output logic         BUSY
);
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  sa, sb, sum_q;
  logic          carry, cout_q;
  logic [CW-1:0] cnt;

  logic s0, c0, c1, bit_sum, bit_carry;

  half_adder u_ha0 (.a(sa[0]), .b(sb[0]), .s(s0),      .c(c0));
  half_adder u_ha1 (.a(s0),    .b(carry), .s(bit_sum), .c(c1));
  assign bit_carry = c0 | c1;

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (IN_VALID) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (OUT_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter holds the index of the bit being added; the final bit is processed
  // on the edge where it already equals N-1, giving exactly N RUN edges.
  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      sa     <= '0;
      sb     <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            sa    <= A;
            sb    <= B;
            carry <= CIN;
            cnt   <= '0;
            sum_q <= '0;
          end
        end
        RUN: begin
          sum_q <= {bit_sum, sum_q[N-1:1]};
          sa    <= {1'b0, sa[N-1:1]};
          sb    <= {1'b0, sb[N-1:1]};
          carry <= bit_carry;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) cout_q <= bit_carry;
        end
        default: ;
      endcase
    end
  end

  assign IN_READY  = (state == IDLE);
  assign BUSY      = (state == RUN);
  assign OUT_VALID = (state == DONE);
  assign SUM       = sum_q;
  assign COUT      = cout_q;
endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Scoreboard bench for serial_adder_sequencer (N=8): directed vectors plus a
// randomised back-to-back run with random output backpressure.

module tb_serial_adder_sequencer;
  localparam int unsigned N = 8;

  logic         CLKIN = 1'b0;
  logic         RESET = 1'b0;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         CIN = 1'b0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic [N-1:0] SUM;
  logic         COUT;
  logic         BUSY;

  serial_adder_sequencer #(.N(N)) dut (
    .CLKIN(CLKIN), .RESET(RESET),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .CIN(CIN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .SUM(SUM), .COUT(COUT), .BUSY(BUSY)
  );

  always #5 CLKIN = ~CLKIN;

  int checks = 0;
  int failures = 0;
  logic [N:0] sb_q[$];
  int unsigned ready_mode = 1;  // 0: low, 1: high, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // OUT_READY driver, offset from the main stimulus to avoid ordering races.
  initial forever begin
    @(posedge CLKIN);
    #2;
    case (ready_mode)
      0:       OUT_READY = 1'b0;
      1:       OUT_READY = 1'b1;
      default: OUT_READY = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares each delivered result with the scoreboard head and checks
  // that a stalled result holds still.
  logic         held_v = 1'b0;
  logic [N:0]   held;
  initial forever begin
    @(negedge CLKIN);
    if (!RESET && OUT_VALID) begin
      if (held_v) check("hold_stable", {23'd0, COUT, SUM}, {23'd0, held});
      if (OUT_READY) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          logic [N:0] e;
          e = sb_q.pop_front();
          check("result", {23'd0, COUT, SUM}, {23'd0, e});
        end
        held_v = 1'b0;
      end else begin
        held   = {COUT, SUM};
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // Present operands until accepted; returns just after the accepting edge.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                      input logic [N:0] exp);
    bit ok;
    ok = 0;
    @(posedge CLKIN);
    #1;
    IN_VALID = 1'b1; A = a; B = b; CIN = c;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLKIN);
      if (IN_READY) begin
        sb_q.push_back(exp);
        @(posedge CLKIN);
        #1;
        ok = 1;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    IN_VALID = 1'b0;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge CLKIN);
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    int busy_cnt, first_valid, first_ready;
    logic [N-1:0] ra, rb;
    logic         rc;

    // Asynchronous reset, observed before any clock edge.
    #1 RESET = 1'b1;
    #1;
    check("rst_in_ready", IN_READY, 1);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_sum", SUM, 0);
    check("rst_cout", COUT, 0);
    repeat (2) @(posedge CLKIN);
    #1 RESET = 1'b0;

    // Basic add with timing profile.
    ready_mode = 1;
    send(8'h5A, 8'h3C, 1'b0, 9'h096);
    busy_cnt = 0; first_valid = 0; first_ready = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge CLKIN);
      if (BUSY) busy_cnt++;
      if (OUT_VALID && first_valid == 0) first_valid = j;
      if (IN_READY && first_ready == 0) first_ready = j;
    end
    check("busy_cycles", busy_cnt, N);
    check("valid_latency", first_valid, N + 1);
    check("ready_return", first_ready, N + 2);

    // Carry ripple through all bits.
    send(8'hFF, 8'h01, 1'b0, 9'h100);
    send(8'hFF, 8'h00, 1'b1, 9'h100);
    send(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    send(8'h00, 8'h00, 1'b0, 9'h000);
    drain(40);

    // Backpressure with operand pulses while RUN/DONE.
    ready_mode = 0;
    @(posedge CLKIN);
    send(8'h12, 8'h34, 1'b1, 9'h047);
    for (int j = 0; j < 16; j++) begin
      @(posedge CLKIN);
      #1;
      IN_VALID = j[0];
      A = 8'h11; B = 8'h11; CIN = 1'b0;
    end
    check("held_valid", OUT_VALID, 1);
    IN_VALID = 1'b0;
    ready_mode = 1;
    drain(10);
    repeat (N + 4) @(negedge CLKIN);
    check("no_capture_busy", BUSY, 0);
    check("no_capture_ready", IN_READY, 1);

    // Reset in the middle of a job: no result may appear.
    send(8'h80, 8'h80, 1'b0, 9'h100);
    repeat (4) @(posedge CLKIN);
    #1 RESET = 1'b1;
    #1;
    void'(sb_q.pop_back());
    check("mid_rst_in_ready", IN_READY, 1);
    check("mid_rst_out_valid", OUT_VALID, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_sum", SUM, 0);
    check("mid_rst_cout", COUT, 0);
    repeat (2) @(posedge CLKIN);
    #1 RESET = 1'b0;
    repeat (N + 3) @(negedge CLKIN);
    check("post_rst_idle", IN_READY, 1);
    send(8'h01, 8'h02, 1'b0, 9'h003);
    drain(20);

    // Randomised back-to-back stream with random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc});
    end
    ready_mode = 1;
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_adder_sequencer.md
Name: serial_adder_sequencer

Overview:
Bit-serial N-bit adder controller. It time-shares one 1-bit full-adder cell across all operand bits, one bit per clock. The cell is built from two HalfAdder instances plus an OR for the carry. Operands are accepted over a valid/ready input handshake, and the sum is returned over a valid/ready output handshake. It is intended for area-constrained iCE40 designs where an N-bit SB_CARRY chain is not affordable.

Parameters:
N, 8, operand/sum width in bits (legal range 2..32)

Ports:
CLKIN  input  1  clock; all state updates on rising edge
RESET  input  1  asynchronous, active-high reset
IN_VALID  input  1  operands A, B, CIN are valid
IN_READY  output  1  block can accept operands
A  input  N  addend
B  input  N  addend
CIN  input  1  carry-in for the LSB
OUT_VALID  output  1  SUM/COUT are valid
OUT_READY  input  1  consumer accepts result
SUM  output  N  (A + B + CIN) mod 2^N
COUT  output  1  carry out of bit N-1
BUSY  output  1  high in RUN state

Behaviour:
- Clocking and reset
  - Single clock domain, CLKIN.
  - RESET is asynchronous, active-high. While RESET is high and on release: state=IDLE, IN_READY=1, OUT_VALID=0, BUSY=0, SUM=0, COUT=0.
  - Internal operand registers, carry flop and bit counter are cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE
  - IN_READY=1.
  - On an edge with IN_VALID=1: latch A into shift register SA, B into SB and CIN into carry flop C; clear counter and SUM; go to RUN.
- RUN
  - IN_READY=0, BUSY=1.
  - Each edge:
    - s = SA[0]^SB[0]^C and c' = majority(SA[0], SB[0], C), via the HA+HA+OR cell.
    - SUM shifts right with s inserted at bit N-1.
    - SA and SB shift right with 0 inserted.
    - C <= c'.
    - Counter increments.
  - On the edge where the counter reaches N-1 (the Nth RUN edge): COUT <= c', go to DONE.
- DONE
  - OUT_VALID=1; IN_READY=0, BUSY=0.
  - SUM and COUT are held stable until OUT_READY=1 is sampled on an edge; then go to IDLE.
  - The next operands can be accepted at the earliest on the edge after returning to IDLE, so there is one idle cycle between jobs.
- Latency: with operands accepted on edge k, OUT_VALID is first high after edge k+N. With OUT_READY tied high, throughput is one result per N+2 cycles.
- Width rule: SUM is exactly N bits; the overflow bit appears only on COUT.
- Ignored inputs:
  - IN_VALID in RUN or DONE has no effect; operands are not captured.
  - OUT_READY outside DONE has no effect.
- Changes to A/B/CIN after acceptance have no effect on the result in progress.
- Reset mid-operation, in RUN or DONE: the job is aborted, all outputs return to their reset values and no result is emitted.
- Outputs are registered or decoded from state only. There is no combinational path from any input to any output.

Test Plan:
- Reset check (N=8): assert RESET mid-cycle with no clock edge -> IN_READY=1, OUT_VALID=0, BUSY=0, SUM=0x00, COUT=0 immediately.
- Basic add: A=0x5A, B=0x3C, CIN=0, OUT_READY=1 -> BUSY high for 8 cycles; OUT_VALID after 8th RUN edge; SUM=0x96, COUT=0; IN_READY=1 again 2 cycles later.
- Full carry ripple: A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1. Also A=0xFF, B=0x00, CIN=1 -> SUM=0x00, COUT=1. Also A=0xFF, B=0xFF, CIN=1 -> SUM=0xFF, COUT=1.
- Backpressure and ignored input:
  - Hold OUT_READY=0 for 5 cycles in DONE -> SUM/COUT/OUT_VALID stable.
  - Pulse IN_VALID with A=0x11 during RUN and DONE -> not captured; the original result is delivered.
- Reset mid-operation: accept 0x80+0x80, assert RESET after 4 RUN edges -> outputs return to reset values, no OUT_VALID. Then 0x01+0x02 -> SUM=0x03, COUT=0.
- Randomised back-to-back: 200 random A/B/CIN with OUT_READY randomly toggled -> every result matches (A+B+CIN) mod 256 with the matching COUT, in order, with none lost or duplicated.
